register_file_param: RTL and testbench
======================================

# register_file_param

Parametrised two-read/one-write register file for the toy processor datapath, replacing the fixed 8×8 register file. It adds configurable width and depth, an optional hardwired-zero R0, and a sequenced bulk-clear engine. The clear engine wipes one entry per cycle under a BUSY/DONE handshake without asserting reset. It sits between the control unit (SA/SB/DR/LD/CLR) and the ALU/writeback mux (DataA/DataB/D_in).

## Interface
- DATA_W, 8: entry width in bits
- DEPTH, 8: number of entries; power of two, ≥2
- ZERO_R0, 0: 1 makes entry 0 read as zero and ignore writes
- ADDR_W: local, $clog2(DEPTH)
- CLK  in  1  single clock; all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- SA  in  ADDR_W  read port A address
- SB  in  ADDR_W  read port B address
- LD  in  1  write enable
- DR  in  ADDR_W  write address
- D_in  in  DATA_W  write data
- CLR  in  1  bulk-clear request, sampled on rising edge
- DataA  out  DATA_W  entry[SA], combinational
- DataB  out  DATA_W  entry[SB], combinational
- BUSY  out  1  high while the clear sequence runs
- DONE  out  1  one-cycle pulse on the last cycle of a clear

## Operation
- Reset (RESET_N=0, any time, including mid-clear): all entries←0, state←IDLE, clear counter←0, BUSY=0, DONE=0. Takes effect without a clock edge.
- State machine: IDLE, CLEARING.
- IDLE:
  - LD=1 writes D_in to entry[DR] at the edge.
  - CLR=1 → CLEARING, counter←0. If LD=1 and CLR=1 arrive together, the write is performed and the clear starts the same edge.
- CLEARING:
  - Each edge writes 0 to entry[counter], then counter+1.
  - On the edge where counter==DEPTH-1, the last entry is cleared and the FSM returns to IDLE.
  - BUSY=1 for exactly DEPTH cycles.
  - DONE=1 during the final CLEARING cycle (counter==DEPTH-1).
- CLEARING is exclusive:
  - LD is ignored; the write is dropped, not queued.
  - CLR is ignored; there is no restart.
- Reads during CLEARING return the current contents. Entries below the counter read 0; the rest read their prior values.
- ZERO_R0=1: DataA/DataB return 0 when the address is 0; writes to DR=0 have no effect.
- Counter width is ADDR_W. It never wraps, because the exit happens at DEPTH-1.

## Timing
- Read latency 0: DataA/DataB follow SA/SB and array contents combinationally.
- Write latency 1: a value written at edge N is visible on the read ports after edge N, or in the same cycle when bypass is enabled (see Configuration).
- Clear latency: CLR sampled at edge N → BUSY rises after N, falls after edge N+DEPTH. DONE is high in the cycle before BUSY falls.
- Outputs after reset: DataA=DataB=0, BUSY=0, DONE=0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In IDLE with LD=1, a read port whose address equals DR returns D_in in the same cycle (write-through).
  - ZERO_R0 still overrides address 0.
  - No bypass during CLEARING.
- REGFILE_BYPASS_EN undefined: the read port returns the stored (old) value until after the edge.

## Structure
- Package regfile_pkg:
  - state enum (ST_IDLE, ST_CLEARING)
  - default DATA_W/DEPTH constants
- Sub-module regfile_clear_seq:
  - owns the FSM, counter, BUSY, DONE
  - outputs a clear-write enable plus address to the top
- Top level owns the array, write arbitration (clear beats LD), the read muxes, bypass, and ZERO_R0 masking.

## Test plan
- Reset, then write 0xA5→R3 and 0x3C→R5; SA=3, SB=5 → DataA=0xA5, DataB=0x3C; assert RESET_N low mid-cycle → both read 0 immediately.
- Bypass: LD=1, DR=2, D_in=0x7E, SA=2 in the same cycle → DataA=0x7E with REGFILE_BYPASS_EN, old value (0x00) without it.
- DEPTH=8, all entries at 0xFF, pulse CLR → BUSY high 8 cycles; DONE on cycle 8; LD to R1 at cycle 3 is dropped; all entries 0 afterwards.
- Clear monitor: at cycle 4 of a clear, R0–R3 read 0 and R4–R7 still read 0xFF; CLR re-pulsed at cycle 5 → no restart, BUSY falls on schedule.
- ZERO_R0=1: write 0x55 to R0 → DataA(SA=0)=0x00; with bypass on, same-cycle read also 0x00.
- DATA_W=16, DEPTH=32: write 0xBEEF to R31, then clear → DONE exactly 32 cycles after CLR; R31 reads 0 afterwards; RESET_N asserted at cycle 10 aborts the clear with BUSY=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
// Optional same-cycle write-through is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks the counter over every entry, one per cycle,
// and reports BUSY/DONE. The state is exported for observation.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_busy,
    output logic              o_done,
    output state_e            o_state
);

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PENULT = ADDR_W'(DEPTH - 2);

    state_e            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_done;

    // DONE is registered one cycle early so it is high while the counter sits on LAST.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_clr) begin
                        r_state <= ST_CLEARING;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEARING: begin
                    if (r_cnt == LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_done <= (r_cnt == PENULT);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_clr_we   = r_busy;
    assign o_clr_addr = r_cnt;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_state    = r_state;

endmodule

// File: rtl/register_file_param.sv
// Two-read/one-write register file with optional hardwired-zero R0 and a
// sequenced bulk clear. Define REGFILE_BYPASS_EN for same-cycle write-through.
module register_file_param
    import regfile_pkg::*;
#(
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int DEPTH   = DEF_DEPTH,
    parameter  int ZERO_R0 = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    input  logic              LD,
    input  logic [ADDR_W-1:0] DR,
    input  logic [DATA_W-1:0] D_in,
    input  logic              CLR,
    output logic [DATA_W-1:0] DataA,
    output logic [DATA_W-1:0] DataB,
    output logic              BUSY,
    output logic              DONE
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    state_e            w_state;
    logic              w_ld_ok;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_data_a;
    logic [DATA_W-1:0] w_data_b;

    regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
        .i_clk      (CLK),
        .i_rst_n    (RESET_N),
        .i_clr      (CLR),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_busy     (BUSY),
        .o_done     (DONE),
        .o_state    (w_state)
    );

    // LD only counts in IDLE; a clear in progress silently drops it.
    assign w_ld_ok = LD && (w_state == ST_IDLE) && !((ZERO_R0 != 0) && (DR == '0));
    assign w_we    = w_clr_we || w_ld_ok;
    assign w_waddr = w_clr_we ? w_clr_addr : DR;
    assign w_wdata = w_clr_we ? '0 : D_in;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_comb begin
        w_data_a = r_mem[SA];
        w_data_b = r_mem[SB];
`ifdef REGFILE_BYPASS_EN
        if (w_ld_ok && (SA == DR)) w_data_a = D_in;
        if (w_ld_ok && (SB == DR)) w_data_b = D_in;
`endif
        if ((ZERO_R0 != 0) && (SA == '0)) w_data_a = '0;
        if ((ZERO_R0 != 0) && (SB == '0)) w_data_b = '0;
    end

    assign DataA = w_data_a;
    assign DataB = w_data_b;

endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param: three configurations
// (8x8, 8x8 with zero R0, 16x32), vector table plus clear/reset sequences.
module tb_register_file_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  // main instance 8x8
  logic       rst_n, ld, clr, busy, done;
  logic [2:0] sa, sb, dr;
  logic [7:0] d_in, data_a, data_b;
  // zero-R0 instance 8x8
  logic       z_rst_n, z_ld, z_clr, z_busy, z_done;
  logic [2:0] z_sa, z_sb, z_dr;
  logic [7:0] z_din, z_data_a, z_data_b;
  // wide instance 16x32
  logic        w_rst_n, w_ld, w_clr, w_busy, w_done;
  logic [4:0]  w_sa, w_sb, w_dr;
  logic [15:0] w_din, w_data_a, w_data_b;

  register_file_param #(.DATA_W(8), .DEPTH(8), .ZERO_R0(0)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .SA(sa), .SB(sb), .LD(ld), .DR(dr), .D_in(d_in),
    .CLR(clr), .DataA(data_a), .DataB(data_b), .BUSY(busy), .DONE(done)
  );

  register_file_param #(.DATA_W(8), .DEPTH(8), .ZERO_R0(1)) u_zero (
    .CLK(clk), .RESET_N(z_rst_n), .SA(z_sa), .SB(z_sb), .LD(z_ld), .DR(z_dr), .D_in(z_din),
    .CLR(z_clr), .DataA(z_data_a), .DataB(z_data_b), .BUSY(z_busy), .DONE(z_done)
  );

  register_file_param #(.DATA_W(16), .DEPTH(32), .ZERO_R0(0)) u_wide (
    .CLK(clk), .RESET_N(w_rst_n), .SA(w_sa), .SB(w_sb), .LD(w_ld), .DR(w_dr), .D_in(w_din),
    .CLR(w_clr), .DataA(w_data_a), .DataB(w_data_b), .BUSY(w_busy), .DONE(w_done)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string name, input logic [15:0] act);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %h expected <nothing queued>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ld;
    logic [2:0] dr;
    logic [7:0] din;
    logic [2:0] sa;
    logic [2:0] sb;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t vecs[9];

  // ---------------- driver tasks ----------------
  task automatic read_pairs_8(input string tag, input int zero_below, input logic [7:0] hi_val);
    for (int j = 0; j < 4; j++) begin
      sa = 3'(j);
      sb = 3'(j + 4);
      push_exp((j < zero_below) ? 16'h0000 : {8'h00, hi_val});
      push_exp(((j + 4) < zero_below) ? 16'h0000 : {8'h00, hi_val});
      #1;
      pop_check($sformatf("%s_r%0d", tag, j), {8'h00, data_a});
      pop_check($sformatf("%s_r%0d", tag, j + 4), {8'h00, data_b});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int done_at;

    rst_n = 0; ld = 0; clr = 0; sa = 0; sb = 0; dr = 0; d_in = 0;
    z_rst_n = 0; z_ld = 0; z_clr = 0; z_sa = 0; z_sb = 0; z_dr = 0; z_din = 0;
    w_rst_n = 0; w_ld = 0; w_clr = 0; w_sa = 0; w_sb = 0; w_dr = 0; w_din = 0;

    vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd5, BYP ? 8'hA5 : 8'h00, 8'h00};
    vecs[1] = '{1'b1, 3'd5, 8'h3C, 3'd3, 3'd5, 8'hA5, BYP ? 8'h3C : 8'h00};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd5, 8'hA5, 8'h3C};
    vecs[3] = '{1'b1, 3'd2, 8'h7E, 3'd2, 3'd3, BYP ? 8'h7E : 8'h00, 8'hA5};
    vecs[4] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 8'h7E, 8'h7E};
    vecs[5] = '{1'b1, 3'd0, 8'h11, 3'd0, 3'd7, BYP ? 8'h11 : 8'h00, 8'h00};
    vecs[6] = '{1'b1, 3'd7, 8'hFF, 3'd0, 3'd7, 8'h11, BYP ? 8'hFF : 8'h00};
    vecs[7] = '{1'b1, 3'd3, 8'hC3, 3'd3, 3'd0, BYP ? 8'hC3 : 8'hA5, 8'h11};
    vecs[8] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 8'hC3, 8'hFF};

    // reset state
    repeat (2) @(negedge clk);
    sa = 3'd7; sb = 3'd4;
    #1;
    check("rst_data_a", {8'h00, data_a}, 16'h0000);
    check("rst_data_b", {8'h00, data_b}, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0000);
    check("rst_done", {15'h0, done}, 16'h0000);
    rst_n = 1; z_rst_n = 1; w_rst_n = 1;

    // table-driven write/read vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ld = vecs[i].ld; dr = vecs[i].dr; d_in = vecs[i].din;
      sa = vecs[i].sa; sb = vecs[i].sb;
      push_exp({8'h00, vecs[i].exp_a});
      push_exp({8'h00, vecs[i].exp_b});
      #2;
      pop_check($sformatf("vec%0d_a", i), {8'h00, data_a});
      pop_check($sformatf("vec%0d_b", i), {8'h00, data_b});
    end

    // asynchronous reset in the middle of a low phase
    @(negedge clk);
    ld = 0; sa = 3'd3; sb = 3'd5;
    #2;
    check("pre_rst_a", {8'h00, data_a}, 16'h00C3);
    check("pre_rst_b", {8'h00, data_b}, 16'h003C);
    #3 rst_n = 0;
    #1;
    check("async_rst_a", {8'h00, data_a}, 16'h0000);
    check("async_rst_b", {8'h00, data_b}, 16'h0000);
    @(negedge clk);
    rst_n = 1;

    // LD and CLR on the same edge: write lands, clear starts
    @(negedge clk);
    ld = 1; dr = 3'd4; d_in = 8'h42; clr = 1;
    @(negedge clk);
    ld = 0; clr = 0; sa = 3'd4;
    #1;
    check("ldclr_busy", {15'h0, busy}, 16'h0001);
    check("ldclr_r4_written", {8'h00, data_a}, 16'h0042);
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      @(negedge clk);
      #1;
      busy_cycles++;
    end
    check("ldclr_busy_end", {15'h0, busy}, 16'h0000);
    check("ldclr_r4_cleared", {8'h00, data_a}, 16'h0000);

    // fill all entries with 0xFF
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ld = 1; dr = 3'(i); d_in = 8'hFF;
    end
    @(negedge clk);
    ld = 0;
    read_pairs_8("fill", 0, 8'hFF);

    // full clear with a dropped LD and an ignored CLR re-pulse
    @(negedge clk);
    clr = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ld = 0; clr = 0;
      if (k == 3) begin ld = 1; dr = 3'd1; d_in = 8'h99; sa = 3'd1; end
      if (k == 5) clr = 1;
      push_exp(16'h0001);
      push_exp((k == 7) ? 16'h0001 : 16'h0000);
      #1;
      pop_check($sformatf("clr_busy_c%0d", k), {15'h0, busy});
      pop_check($sformatf("clr_done_c%0d", k), {15'h0, done});
      if (k == 3) check("clr_no_bypass_r1", {8'h00, data_a}, 16'h0000);
      if (k == 4) read_pairs_8("clr_mid", 4, 8'hFF);
    end
    @(negedge clk);
    ld = 0; clr = 0;
    #1;
    check("clr_busy_fall", {15'h0, busy}, 16'h0000);
    check("clr_done_fall", {15'h0, done}, 16'h0000);
    read_pairs_8("clr_after", 8, 8'hFF);
    @(negedge clk);
    #1;
    check("clr_no_restart", {15'h0, busy}, 16'h0000);

    // zero-R0 instance
    @(negedge clk);
    z_ld = 1; z_dr = 3'd0; z_din = 8'h55; z_sa = 3'd0; z_sb = 3'd1;
    #1;
    check("z_r0_same_cycle", {8'h00, z_data_a}, 16'h0000);
    @(negedge clk);
    z_dr = 3'd1; z_din = 8'h66;
    #1;
    check("z_r0_after_write", {8'h00, z_data_a}, 16'h0000);
    check("z_r1_same_cycle", {8'h00, z_data_b}, BYP ? 16'h0066 : 16'h0000);
    @(negedge clk);
    z_ld = 0;
    #1;
    check("z_r1_stored", {8'h00, z_data_b}, 16'h0066);

    // wide instance: DONE timing over 32 entries
    @(negedge clk);
    w_ld = 1; w_dr = 5'd31; w_din = 16'hBEEF;
    @(negedge clk);
    w_ld = 0; w_sa = 5'd31;
    #1;
    check("w_r31_written", w_data_a, 16'hBEEF);
    w_clr = 1;
    @(negedge clk);
    w_clr = 0;
    busy_cycles = 0;
    done_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (w_done && done_at < 0) done_at = k;
      if (!w_busy) break;
      busy_cycles++;
    end
    check("w_busy_cycles", 16'(busy_cycles), 16'd32);
    check("w_done_cycle", 16'(done_at), 16'd31);
    check("w_r31_cleared", w_data_a, 16'h0000);

    // wide instance: reset aborts a clear in progress
    @(negedge clk);
    w_ld = 1; w_dr = 5'd31; w_din = 16'hBEEF;
    @(negedge clk);
    w_ld = 0; w_clr = 1;
    @(negedge clk);
    w_clr = 0;
    repeat (10) @(negedge clk);
    #1;
    check("w_abort_busy_before", {15'h0, w_busy}, 16'h0001);
    check("w_abort_r31_before", w_data_a, 16'hBEEF);
    w_rst_n = 0;
    #1;
    check("w_abort_busy", {15'h0, w_busy}, 16'h0000);
    check("w_abort_done", {15'h0, w_done}, 16'h0000);
    check("w_abort_r31", w_data_a, 16'h0000);
    @(negedge clk);
    w_rst_n = 1;

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
